// File: rtl/dice_pkg.sv
// Shared definitions for the two-die roll controller and the seven-segment
// decoders downstream of it: die value range, FSM state codes and the
// wrap-around step used by both die counters.
package dice_pkg;

    // Legal die faces; the segment decoders use the same bounds.
    localparam logic [2:0] DIE_MIN = 3'd1;
    localparam logic [2:0] DIE_MAX = 3'd6;

    // Roll controller states, kept as plain constants so older code that
    // compares raw 2-bit codes keeps working.
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t ROLL = 2'd1;
    localparam state_t SHOW = 2'd2;

    // Advance a die by one face. Out-of-range codes (0 and 7) behave as if
    // the die were showing the top face, so they recover to DIE_MIN.
    function automatic logic [2:0] next_die(input logic [2:0] v);
        logic [2:0] result;
        if ((v >= DIE_MAX) || (v < DIE_MIN)) begin
            result = DIE_MIN;
        end else begin
            result = v + 3'd1;
        end
        return result;
    endfunction

    // True when a value is a legal die face.
    function automatic logic is_valid_die(input logic [2:0] v);
        return (v >= DIE_MIN) && (v <= DIE_MAX);
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Roll switch conditioning: a two-flop synchroniser followed by a counter
// that only accepts a new switch level after it has been seen for
// DEBOUNCE_CYCLES consecutive synchronised samples.
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_async,
    output logic sw_stable
);

    // Counter is wide enough for DEBOUNCE_CYCLES = 1 as well.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sw_sync;
    logic [CNT_W-1:0] deb_cnt;

    // Bring the raw switch into the clock domain; sync_meta may go metastable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sw_sync   <= 1'b0;
        end else begin
            sync_meta <= sw_async;
            sw_sync   <= sync_meta;
        end
    end

    // Count disagreeing samples; the accepting sample toggles the stable level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt   <= '0;
            sw_stable <= 1'b0;
        end else if (sw_sync == sw_stable) begin
            deb_cnt <= '0;
        end else if (deb_cnt == CNT_LAST) begin
            deb_cnt   <= '0;
            sw_stable <= ~sw_stable;
        end else begin
            deb_cnt <= deb_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dice_roll_ctrl.sv
// Two-die roll controller. While the debounced switch is held, DIE1 steps
// every cycle and DIE2 every DIE2_DIV cycles; releasing the switch freezes
// both dice and, on doubles, pulses the buzzer for BUZZ_CYCLES cycles.
// Every output comes straight from a flop.
module dice_roll_ctrl
    import dice_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DIE2_DIV        = 3,
    parameter int BUZZ_CYCLES     = 8
) (
    input  logic       CLK,
    input  logic       CLR_n,
    input  logic       SW,
    output logic [2:0] DIE1,
    output logic [2:0] DIE2,
    output logic       ROLLING,
    output logic       BUZZER
);

    localparam int DIV_W  = $clog2(DIE2_DIV);
    localparam int BUZZ_W = $clog2(BUZZ_CYCLES + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIE2_DIV - 1);
    localparam logic [BUZZ_W-1:0] BUZZ_LOAD = BUZZ_W'(BUZZ_CYCLES);

    logic              sw_stable;
    logic              sw_stable_d;
    logic              sw_rise;
    logic              sw_fall;

    state_t            state;
    state_t            state_next;
    logic [2:0]        die1;
    logic [2:0]        die1_next;
    logic [2:0]        die2;
    logic [2:0]        die2_next;
    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_next;
    logic [BUZZ_W-1:0] buzz_cnt;
    logic [BUZZ_W-1:0] buzz_next;
    logic              rolling_q;
    logic              buzzer_q;

    sw_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw_debounce (
        .clk      (CLK),
        .rst_n    (CLR_n),
        .sw_async (SW),
        .sw_stable(sw_stable)
    );

    // Delayed copy of the debounced switch for edge detection.
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            sw_stable_d <= 1'b0;
        end else begin
            sw_stable_d <= sw_stable;
        end
    end

    assign sw_rise = sw_stable & ~sw_stable_d;
    assign sw_fall = ~sw_stable & sw_stable_d;

    // Next-state logic for the FSM, dice, DIE2 divider and buzz counter.
    // Entering ROLL already steps DIE1 and restarts the divider; the stop
    // cycle touches neither die so the frozen faces are the last ones shown.
    always_comb begin
        state_next = state;
        die1_next  = die1;
        die2_next  = die2;
        div_next   = div_cnt;
        buzz_next  = buzz_cnt;
        case (state)
            IDLE: begin
                if (sw_rise) begin
                    state_next = ROLL;
                    die1_next  = next_die(die1);
                    div_next   = '0;
                    buzz_next  = '0;
                end
            end
            ROLL: begin
                if (sw_fall) begin
                    state_next = SHOW;
                    buzz_next  = (die1 == die2) ? BUZZ_LOAD : '0;
                end else begin
                    die1_next = next_die(die1);
                    if (div_cnt == DIV_LAST) begin
                        die2_next = next_die(die2);
                        div_next  = '0;
                    end else begin
                        div_next = div_cnt + DIV_W'(1);
                    end
                end
            end
            SHOW: begin
                if (sw_rise) begin
                    state_next = ROLL;
                    die1_next  = next_die(die1);
                    div_next   = '0;
                    buzz_next  = '0;
                end else if (buzz_cnt != '0) begin
                    buzz_next = buzz_cnt - BUZZ_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Die value registers, both start on the lowest face.
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            die1 <= DIE_MIN;
            die2 <= DIE_MIN;
        end else begin
            die1 <= die1_next;
            die2 <= die2_next;
        end
    end

    // DIE2 rate divider and buzzer length counter.
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            div_cnt  <= '0;
            buzz_cnt <= '0;
        end else begin
            div_cnt  <= div_next;
            buzz_cnt <= buzz_next;
        end
    end

    // Status outputs are registered from the next-state values so they line
    // up with the state and counter they describe.
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            rolling_q <= 1'b0;
            buzzer_q  <= 1'b0;
        end else begin
            rolling_q <= (state_next == ROLL);
            buzzer_q  <= (buzz_next != '0);
        end
    end

    assign DIE1    = die1;
    assign DIE2    = die2;
    assign ROLLING = rolling_q;
    assign BUZZER  = buzzer_q;

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Directed bench for dice_roll_ctrl at default parameters. Expected outputs
// come from a closed-form model of the dice (faces stepped per cycle count)
// and are queued as each step is driven, then popped against the DUT #1
// after the clock edge.
module tb_dice_roll_ctrl;

    localparam int BUZZ = 8;

    logic       CLK;
    logic       CLR_n;
    logic       SW;
    logic [2:0] DIE1;
    logic [2:0] DIE2;
    logic       ROLLING;
    logic       BUZZER;

    typedef struct packed {
        logic [2:0] d1;
        logic [2:0] d2;
        logic       roll;
        logic       buzz;
    } exp_t;

    exp_t  expQ[$];
    string tagQ[$];

    int checkCount = 0;
    int errorCount = 0;
    int curD1      = 1;
    int curD2      = 1;
    int buzzRem    = 0;

    dice_roll_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .DIE2_DIV       (3),
        .BUZZ_CYCLES    (BUZZ)
    ) dut (
        .CLK    (CLK),
        .CLR_n  (CLR_n),
        .SW     (SW),
        .DIE1   (DIE1),
        .DIE2   (DIE2),
        .ROLLING(ROLLING),
        .BUZZER (BUZZER)
    );

    // Free-running 100 MHz clock.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Hard stop in case the directed sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 200us");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int stepDie(input int v, input int n);
        return ((v - 1 + n) % 6) + 1;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic swValue);
        SW = swValue;
    endtask

    task automatic expectOutputs(input int d1, input int d2, input logic roll,
                                 input logic buzz, input string tag);
        exp_t e;
        e.d1 = 3'(d1);
        e.d2 = 3'(d2);
        e.roll = roll;
        e.buzz = buzz;
        expQ.push_back(e);
        tagQ.push_back(tag);
    endtask

    task automatic checkOutput();
        exp_t  e;
        string tag;
        checkCount++;
        assert (expQ.size() > 0) else begin
            errorCount++;
            $error("[TB] FAIL scoreboard_empty: observed 0 entries, expected 1");
        end
        if (expQ.size() > 0) begin
            e   = expQ.pop_front();
            tag = tagQ.pop_front();
            checkCount++;
            assert (DIE1 === e.d1) else begin
                errorCount++;
                $error("[TB] FAIL %s DIE1: observed %0d expected %0d", tag, DIE1, e.d1);
            end
            checkCount++;
            assert (DIE2 === e.d2) else begin
                errorCount++;
                $error("[TB] FAIL %s DIE2: observed %0d expected %0d", tag, DIE2, e.d2);
            end
            checkCount++;
            assert (ROLLING === e.roll) else begin
                errorCount++;
                $error("[TB] FAIL %s ROLLING: observed %b expected %b", tag, ROLLING, e.roll);
            end
            checkCount++;
            assert (BUZZER === e.buzz) else begin
                errorCount++;
                $error("[TB] FAIL %s BUZZER: observed %b expected %b", tag, BUZZER, e.buzz);
            end
        end
    endtask

    task automatic checkFrozen(input string tag, input logic [2:0] e1, input logic [2:0] e2);
        checkCount++;
        assert (DIE1 === e1 && DIE2 === e2) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed %0d/%0d expected %0d/%0d", tag, DIE1, DIE2, e1, e2);
        end
    endtask

    task automatic holdCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            if (buzzRem > 0) buzzRem--;
            expectOutputs(curD1, curD2, 1'b0, buzzRem > 0, tag);
            checkOutput();
        end
    endtask

    // One complete roll: press, wait out the start latency, roll until the
    // last ROLL edge kLast (counted from ROLL entry), then the stop edge.
    task automatic doRoll(input int kLast, input bit glitch);
        int a;
        int b;
        a = curD1;
        b = curD2;
        applyStimulus(1'b1);
        for (int e = 0; e < 6; e++) begin
            tick();
            if (buzzRem > 0) buzzRem--;
            expectOutputs(curD1, curD2, 1'b0, buzzRem > 0, "start_wait");
            checkOutput();
        end
        for (int k = 0; k <= kLast; k++) begin
            if (glitch && k == 3) applyStimulus(1'b0);
            if (glitch && k == 6) applyStimulus(1'b1);
            if (k == kLast - 5) applyStimulus(1'b0);
            tick();
            buzzRem = 0;
            expectOutputs(stepDie(a, k + 1), stepDie(b, k / 3), 1'b1, 1'b0,
                          (k == 0) ? "roll_entry" : "rolling");
            checkOutput();
        end
        tick();
        curD1   = stepDie(a, kLast + 1);
        curD2   = stepDie(b, kLast / 3);
        buzzRem = (curD1 == curD2) ? BUZZ : 0;
        expectOutputs(curD1, curD2, 1'b0, buzzRem > 0, "stop_edge");
        checkOutput();
    endtask

    initial begin
        CLR_n = 1'b1;
        SW    = 1'b0;

        // Asynchronous reset takes effect between clock edges.
        #2;
        CLR_n = 1'b0;
        #1;
        expectOutputs(1, 1, 1'b0, 1'b0, "reset_async");
        checkOutput();
        tick();
        tick();
        expectOutputs(1, 1, 1'b0, 1'b0, "reset_held");
        checkOutput();
        CLR_n = 1'b1;

        $display("[TB] idle hold after reset release");
        holdCycles(20, "idle_hold");

        $display("[TB] 3-cycle glitch while idle");
        applyStimulus(1'b1);
        holdCycles(3, "idle_glitch");
        applyStimulus(1'b0);
        holdCycles(10, "idle_after_glitch");

        $display("[TB] first roll with low glitch mid-roll");
        doRoll(23, 1'b1);
        checkFrozen("frozen_roll1", 3'd1, 3'd2);
        holdCycles(5, "show_roll1");

        $display("[TB] stop without doubles at 4/2");
        doRoll(20, 1'b0);
        checkFrozen("frozen_4_2", 3'd4, 3'd2);
        holdCycles(12, "show_4_2");

        doRoll(15, 1'b0);
        checkFrozen("frozen_2_1", 3'd2, 3'd1);
        holdCycles(3, "show_2_1");

        $display("[TB] doubles at 5/5, full buzzer pulse");
        doRoll(14, 1'b0);
        checkFrozen("frozen_5_5", 3'd5, 3'd5);
        holdCycles(10, "buzz_5_5");

        $display("[TB] doubles at 4/4, restart while buzzing");
        doRoll(16, 1'b0);
        checkFrozen("frozen_4_4", 3'd4, 3'd4);
        doRoll(12, 1'b0);
        checkFrozen("frozen_5_2", 3'd5, 3'd2);
        holdCycles(3, "show_5_2");

        $display("[TB] reset in the middle of a roll");
        applyStimulus(1'b1);
        for (int e = 0; e < 6; e++) begin
            tick();
            expectOutputs(curD1, curD2, 1'b0, 1'b0, "pre_reset_wait");
            checkOutput();
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            expectOutputs(stepDie(curD1, k + 1), stepDie(curD2, k / 3), 1'b1, 1'b0,
                          "pre_reset_roll");
            checkOutput();
        end
        #2;
        CLR_n = 1'b0;
        #1;
        expectOutputs(1, 1, 1'b0, 1'b0, "reset_mid_roll");
        checkOutput();
        tick();
        expectOutputs(1, 1, 1'b0, 1'b0, "reset_mid_roll_held");
        checkOutput();
        curD1   = 1;
        curD2   = 1;
        buzzRem = 0;
        CLR_n   = 1'b1;

        $display("[TB] switch held high through reset release");
        doRoll(13, 1'b0);
        checkFrozen("frozen_after_reset", 3'd3, 3'd5);
        holdCycles(3, "show_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
